multi_tick_gen: RTL and testbench

- Multi-channel programmable tick generator that replaces fixed single-period clock-delay pulsing in the crypto test harness.
- Drives scope triggers, AES start strobes and capture windows.
- Each channel has a runtime-programmable period, pulse width and mode (periodic or one-shot), with start/stop control and busy/done status.
- Sits between the control/UART register block and the AES core / trigger pins.

---
 rtl/multi_tick_pkg.sv | 9 +
 rtl/multi_tick_if.sv | 26 ++
 rtl/tick_channel.sv | 99 +++++++++
 rtl/multi_tick_gen.sv | 33 +++
 tb/tb_multi_tick_gen.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/multi_tick_pkg.sv
// multi_tick_pkg: shared types and helpers for the multi-channel tick generator
package multi_tick_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_tick_if.sv
// multi_tick_if: config/control/status bundle between register block and tick generator
interface multi_tick_if #(
  parameter int CH = 4,
  parameter int CNT_W = 16
);
  import multi_tick_pkg::*;
  localparam int CH_W = ch_w(CH);
  logic cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic cfg_mode;
  logic [CH-1:0] start;
  logic [CH-1:0] stop;
  logic [CH-1:0] tick;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;
  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_width, cfg_mode, start, stop,
    input tick, busy, done
  );
  modport slave (
    input cfg_we, cfg_ch, cfg_period, cfg_width, cfg_mode, start, stop,
    output tick, busy, done
  );
endinterface

// File: rtl/tick_channel.sv
// tick_channel: one programmable tick channel with shadowed config, period and width counters
module tick_channel
  import multi_tick_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DEF_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic cfg_mode,
  input  logic start,
  input  logic stop,
  output logic tick,
  output logic busy,
  output logic done
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_P = (DEF_PERIOD < 1) ? ONE : CNT_W'(DEF_PERIOD);
  state_t state;
  logic [CNT_W-1:0] sh_p, sh_w, act_p, act_w, cnt, wcnt;
  logic sh_m, act_m;
  logic [CNT_W-1:0] nx_p, nx_w, ld_p, ld_w1, ld_w;
  logic nx_m, bnd, fin;
  // A write in the same cycle as a load is forwarded so start/boundary see the new values
  always_comb begin
    nx_p = we ? cfg_period : sh_p;
    nx_w = we ? cfg_width : sh_w;
    nx_m = we ? cfg_mode : sh_m;
    ld_p = (nx_p == '0) ? ONE : nx_p;
    ld_w1 = (nx_w == '0) ? ONE : nx_w;
    ld_w = (ld_w1 > ld_p) ? ld_p : ld_w1;
    bnd = (state == RUN) && (cnt == act_p - ONE);
    fin = (state == RUN) && tick && (wcnt == '0) && (act_m == MODE_ONESHOT);
  end
  // Channel FSM: stop beats start, start restarts, otherwise count toward period boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_p <= DEF_P;
      sh_w <= ONE;
      sh_m <= MODE_PERIODIC;
      act_p <= DEF_P;
      act_w <= ONE;
      act_m <= MODE_PERIODIC;
      cnt <= '0;
      wcnt <= '0;
      tick <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (we) begin
        sh_p <= cfg_period;
        sh_w <= cfg_width;
        sh_m <= cfg_mode;
      end
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        cnt <= '0;
        wcnt <= '0;
        tick <= 1'b0;
        busy <= 1'b0;
      end else if (start) begin
        state <= RUN;
        cnt <= '0;
        wcnt <= '0;
        tick <= 1'b0;
        busy <= 1'b1;
        act_p <= ld_p;
        act_w <= ld_w;
        act_m <= nx_m;
      end else if (state == RUN) begin
        if (fin) begin
          state <= IDLE;
          cnt <= '0;
          tick <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end else if (bnd) begin
          cnt <= '0;
          tick <= 1'b1;
          wcnt <= act_w - ONE;
          act_p <= ld_p;
          act_w <= ld_w;
          act_m <= nx_m;
        end else begin
          cnt <= cnt + ONE;
          if (tick) begin
            if (wcnt == '0) tick <= 1'b0;
            else wcnt <= wcnt - ONE;
          end
        end
      end
    end
  end
endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: CH independent programmable tick channels behind one config port
module multi_tick_gen
  import multi_tick_pkg::*;
#(
  parameter int CH = 4,
  parameter int CNT_W = 16,
  parameter int DEF_PERIOD = 10
) (
  input logic clk,
  input logic rst,
  multi_tick_if.slave bus
);
  logic [CH-1:0] we_v, tick_v, busy_v, done_v;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign we_v[i] = bus.cfg_we && (32'(bus.cfg_ch) == i);
    tick_channel #(.CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD)) u_ch (
      .clk(clk),
      .rst(rst),
      .we(we_v[i]),
      .cfg_period(bus.cfg_period),
      .cfg_width(bus.cfg_width),
      .cfg_mode(bus.cfg_mode),
      .start(bus.start[i]),
      .stop(bus.stop[i]),
      .tick(tick_v[i]),
      .busy(busy_v[i]),
      .done(done_v[i])
    );
  end
  assign bus.tick = tick_v;
  assign bus.busy = busy_v;
  assign bus.done = done_v;
endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: directed scoreboard bench for multi_tick_gen
module tb_multi_tick_gen;
  localparam int CH = 3;
  localparam int CNT_W = 16;
  typedef struct {
    string tag;
    logic [CH-1:0] t;
    logic [CH-1:0] b;
    logic [CH-1:0] d;
  } exp_t;
  logic clk, rst;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  multi_tick_if #(.CH(CH), .CNT_W(CNT_W)) bus ();
  multi_tick_gen #(.CH(CH), .CNT_W(CNT_W), .DEF_PERIOD(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [CH-1:0] t, input logic [CH-1:0] b, input logic [CH-1:0] d);
    checks++;
    assert ({bus.tick, bus.busy, bus.done} === {t, b, d}) else begin
      errors++;
      $error("FAIL %s: got tick=%b busy=%b done=%b, expected tick=%b busy=%b done=%b",
             tag, bus.tick, bus.busy, bus.done, t, b, d);
    end
  endtask
  task automatic push(input string tag, input logic [CH-1:0] t, input logic [CH-1:0] b, input logic [CH-1:0] d);
    exp_t e;
    e.tag = tag;
    e.t = t;
    e.b = b;
    e.d = d;
    q.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty, got tick=%b, expected an entry", bus.tick);
    end else begin
      e = q.pop_front();
      chk(e.tag, e.t, e.b, e.d);
    end
  endtask
  task automatic cfg(input int ch, input int p, input int w, input logic m);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 2'(ch);
    bus.cfg_period = CNT_W'(p);
    bus.cfg_width = CNT_W'(w);
    bus.cfg_mode = m;
  endtask
  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_period = '0;
    bus.cfg_width = '0;
    bus.cfg_mode = 1'b0;
    bus.start = '0;
    bus.stop = '0;
    #12 rst = 1'b0;
    #1 chk("reset", 3'b000, 3'b000, 3'b000);
    // default period 10 on ch0
    push("start0", 3'b000, 3'b001, 3'b000);
    bus.start = 3'b001;
    step();
    bus.start = '0;
    for (int m = 0; m < 3; m++) begin
      for (int j = 0; j < 9; j++) push("gap0", 3'b000, 3'b001, 3'b000);
      push("tick0", 3'b001, 3'b001, 3'b000);
    end
    repeat (30) step();
    push("stop0", 3'b000, 3'b000, 3'b000);
    bus.stop = 3'b001;
    step();
    bus.stop = '0;
    // ch1 P=5 W=3 periodic
    cfg(1, 5, 3, 1'b0);
    push("cfg1", 3'b000, 3'b000, 3'b000);
    step();
    bus.cfg_we = 1'b0;
    push("start1", 3'b000, 3'b010, 3'b000);
    bus.start = 3'b010;
    step();
    bus.start = '0;
    for (int j = 1; j <= 15; j++)
      push("w3p5", (j >= 5 && j % 5 < 3) ? 3'b010 : 3'b000, 3'b010, 3'b000);
    repeat (15) step();
    push("stop1", 3'b000, 3'b000, 3'b000);
    bus.stop = 3'b010;
    step();
    bus.stop = '0;
    // W=7 clamped to P=5, config written in the same cycle as start
    cfg(1, 5, 7, 1'b0);
    bus.start = 3'b010;
    push("clamp_start", 3'b000, 3'b010, 3'b000);
    step();
    bus.cfg_we = 1'b0;
    bus.start = '0;
    for (int j = 1; j <= 12; j++) push("clamp", (j >= 5) ? 3'b010 : 3'b000, 3'b010, 3'b000);
    repeat (12) step();
    push("stop1b", 3'b000, 3'b000, 3'b000);
    bus.stop = 3'b010;
    step();
    bus.stop = '0;
    // ch2 one-shot P=4 W=2
    cfg(2, 4, 2, 1'b1);
    push("cfg2", 3'b000, 3'b000, 3'b000);
    step();
    bus.cfg_we = 1'b0;
    push("os_start", 3'b000, 3'b100, 3'b000);
    bus.start = 3'b100;
    step();
    bus.start = '0;
    for (int j = 1; j <= 3; j++) push("os_wait", 3'b000, 3'b100, 3'b000);
    push("os_tick", 3'b100, 3'b100, 3'b000);
    push("os_tick", 3'b100, 3'b100, 3'b000);
    push("os_done", 3'b000, 3'b000, 3'b100);
    for (int j = 7; j <= 10; j++) push("os_idle", 3'b000, 3'b000, 3'b000);
    repeat (10) step();
    // start and stop together: stop wins
    bus.start = 3'b001;
    bus.stop = 3'b001;
    push("start_stop", 3'b000, 3'b000, 3'b000);
    step();
    bus.start = '0;
    bus.stop = '0;
    push("start_stop_idle", 3'b000, 3'b000, 3'b000);
    step();
    // stop in the middle of a one-shot pulse
    push("os2_start", 3'b000, 3'b100, 3'b000);
    bus.start = 3'b100;
    step();
    bus.start = '0;
    for (int j = 1; j <= 3; j++) push("os2_wait", 3'b000, 3'b100, 3'b000);
    push("os2_tick", 3'b100, 3'b100, 3'b000);
    repeat (4) step();
    push("stop_mid", 3'b000, 3'b000, 3'b000);
    bus.stop = 3'b100;
    step();
    bus.stop = '0;
    for (int j = 0; j < 3; j++) push("no_done", 3'b000, 3'b000, 3'b000);
    repeat (3) step();
    // shadow update: P=8 running, write P=3 two cycles in
    cfg(2, 8, 1, 1'b0);
    push("cfg2p", 3'b000, 3'b000, 3'b000);
    step();
    bus.cfg_we = 1'b0;
    push("sh_start", 3'b000, 3'b100, 3'b000);
    bus.start = 3'b100;
    step();
    bus.start = '0;
    for (int j = 1; j <= 17; j++)
      push("shadow", (j == 8 || (j > 8 && (j - 8) % 3 == 0)) ? 3'b100 : 3'b000, 3'b100, 3'b000);
    for (int j = 1; j <= 17; j++) begin
      if (j == 2) cfg(2, 3, 1, 1'b0);
      else bus.cfg_we = 1'b0;
      step();
    end
    bus.cfg_we = 1'b0;
    // async reset between edges while tick[2] is high
    #2 rst = 1'b1;
    #1 chk("async_rst", 3'b000, 3'b000, 3'b000);
    #2 rst = 1'b0;
    // out-of-range channel write changes nothing
    cfg(3, 2, 2, 1'b1);
    push("cfg_oor", 3'b000, 3'b000, 3'b000);
    step();
    bus.cfg_we = 1'b0;
    push("oor_start", 3'b000, 3'b111, 3'b000);
    bus.start = 3'b111;
    step();
    bus.start = '0;
    for (int j = 1; j <= 9; j++) push("oor_wait", 3'b000, 3'b111, 3'b000);
    push("oor_tick", 3'b111, 3'b111, 3'b000);
    repeat (10) step();
    push("oor_stop", 3'b000, 3'b000, 3'b000);
    bus.stop = 3'b111;
    step();
    bus.stop = '0;
    // P=0 W=0 behaves as P=1: tick constantly high
    cfg(0, 0, 0, 1'b0);
    bus.start = 3'b001;
    push("p0_start", 3'b000, 3'b001, 3'b000);
    step();
    bus.cfg_we = 1'b0;
    bus.start = '0;
    for (int j = 1; j <= 5; j++) push("p0_high", 3'b001, 3'b001, 3'b000);
    repeat (5) step();
    push("p0_stop", 3'b000, 3'b000, 3'b000);
    bus.stop = 3'b001;
    step();
    bus.stop = '0;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_left: %0d entries remain, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
